// File: rtl/morse_pkg.sv
// Shared types, constants and tables for the Morse receiver: FSM state encoding,
// symbol-pattern to character-code lookup, and the seven-segment glyph table.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2,
    ST_EMIT  = 2'd3
  } state_t;

  localparam logic [5:0] CHAR_INVALID = 6'd63;
  localparam logic [6:0] SEG_INVALID  = 7'b1000000;

  // Segments {g,f,e,d,c,b,a}; entries 0..25 are A..Z, 26..35 are 0..9.
  localparam logic [6:0] SEG_TAB [36] = '{
    7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h76, 7'h30, 7'h1E,
    7'h75, 7'h38, 7'h37, 7'h54, 7'h5C, 7'h73, 7'h67, 7'h50, 7'h6D, 7'h78,
    7'h3E, 7'h1C, 7'h2A, 7'h49, 7'h6E, 7'h5B,
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // pat holds the symbols MSB-first (1 = dash); it is right-aligned before matching.
  function automatic logic [5:0] morse_lookup(input logic [2:0] len, input logic [5:0] pat);
    logic [5:0] r;
    logic [5:0] code;
    r    = pat >> (3'd6 - len);
    code = CHAR_INVALID;
    case ({len, r})
      {3'd2, 6'd1}:  code = 6'd0;
      {3'd4, 6'd8}:  code = 6'd1;
      {3'd4, 6'd10}: code = 6'd2;
      {3'd3, 6'd4}:  code = 6'd3;
      {3'd1, 6'd0}:  code = 6'd4;
      {3'd4, 6'd2}:  code = 6'd5;
      {3'd3, 6'd6}:  code = 6'd6;
      {3'd4, 6'd0}:  code = 6'd7;
      {3'd2, 6'd0}:  code = 6'd8;
      {3'd4, 6'd7}:  code = 6'd9;
      {3'd3, 6'd5}:  code = 6'd10;
      {3'd4, 6'd4}:  code = 6'd11;
      {3'd2, 6'd3}:  code = 6'd12;
      {3'd2, 6'd2}:  code = 6'd13;
      {3'd3, 6'd7}:  code = 6'd14;
      {3'd4, 6'd6}:  code = 6'd15;
      {3'd4, 6'd13}: code = 6'd16;
      {3'd3, 6'd2}:  code = 6'd17;
      {3'd3, 6'd0}:  code = 6'd18;
      {3'd1, 6'd1}:  code = 6'd19;
      {3'd3, 6'd1}:  code = 6'd20;
      {3'd4, 6'd1}:  code = 6'd21;
      {3'd3, 6'd3}:  code = 6'd22;
      {3'd4, 6'd9}:  code = 6'd23;
      {3'd4, 6'd11}: code = 6'd24;
      {3'd4, 6'd12}: code = 6'd25;
      {3'd5, 6'd31}: code = 6'd26;
      {3'd5, 6'd15}: code = 6'd27;
      {3'd5, 6'd7}:  code = 6'd28;
      {3'd5, 6'd3}:  code = 6'd29;
      {3'd5, 6'd1}:  code = 6'd30;
      {3'd5, 6'd0}:  code = 6'd31;
      {3'd5, 6'd16}: code = 6'd32;
      {3'd5, 6'd24}: code = 6'd33;
      {3'd5, 6'd28}: code = 6'd34;
      {3'd5, 6'd30}: code = 6'd35;
      default:       code = CHAR_INVALID;
    endcase
    return code;
  endfunction

  function automatic logic [6:0] seg_of(input logic [5:0] code);
    return (code < 6'd36) ? SEG_TAB[code] : SEG_INVALID;
  endfunction

endpackage

// File: rtl/morse_debounce.sv
// Debouncer: the output follows the input only after DEBOUNCE_TICKS consecutive
// samples that differ from the current output. Used when MORSE_DEBOUNCE_EN is defined.
module morse_debounce #(
  parameter int DEBOUNCE_TICKS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

  logic [DW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dout  <= 1'b0;
    end else if (din == dout) begin
      cnt_q <= '0;
    end else if (cnt_q == DW'(DEBOUNCE_TICKS - 1)) begin
      dout  <= din;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DW'(1);
    end
  end

endmodule

// File: rtl/morse_rx_decoder.sv
// Morse key receiver: times presses/releases, collects dots and dashes, decodes
// characters into a valid/ready output stage. Define MORSE_DEBOUNCE_EN to debounce the key.
module morse_rx_decoder
  import morse_pkg::*;
#(
  parameter int TICKS_PER_UNIT  = 1500,
  parameter int DASH_UNITS      = 2,
  parameter int CHAR_GAP_UNITS  = 3,
  parameter int WORD_GAP_UNITS  = 7,
  parameter int MAX_SYM         = 5,
  parameter int MIN_PRESS_TICKS = 8,
  parameter int DEBOUNCE_TICKS  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button,
  output logic [5:0] char_code,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       word_gap,
  output logic [6:0] seg_out,
  output logic       overflow,
  output logic       dropped,
  output state_t     dbg_state
);

  localparam int CNT_W = $clog2(WORD_GAP_UNITS * TICKS_PER_UNIT + 1);
  localparam logic [CNT_W-1:0] MIN_T   = CNT_W'(MIN_PRESS_TICKS);
  localparam logic [CNT_W-1:0] DASH_T  = CNT_W'(DASH_UNITS * TICKS_PER_UNIT);
  localparam logic [CNT_W-1:0] CHAR_T  = CNT_W'(CHAR_GAP_UNITS * TICKS_PER_UNIT);
  localparam logic [CNT_W-1:0] WORD_T  = CNT_W'(WORD_GAP_UNITS * TICKS_PER_UNIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [2:0]       MAX_LEN = 3'(MAX_SYM);

  // Handshake: a character transfers on a cycle where char_valid && char_ready;
  // char_valid and char_code hold steady until that cycle.

  logic [1:0] sync_q;
  logic       key;
  logic       key_q;
  logic       rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      key_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], button};
      key_q  <= key;
    end
  end

`ifdef MORSE_DEBOUNCE_EN
  morse_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sync_q[1]),
    .dout (key)
  );
`else
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = (DEBOUNCE_TICKS > 0);
  assign key = sync_q[1];
`endif

  assign rise = key & ~key_q;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [MAX_SYM-1:0] buf_q, buf_d;
  logic [2:0]         len_q, len_d;
  logic               bad_q, bad_d;
  logic               armed_q, armed_d;
  logic               ovf_set, wg_d, emit;
  logic [5:0]         pat, emit_code;
  logic               hs;

  assign pat       = 6'(buf_q) << (6 - MAX_SYM);
  assign emit_code = bad_q ? CHAR_INVALID : morse_lookup(len_q, pat);
  assign hs        = char_valid & char_ready;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      len_q   <= '0;
      bad_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      bad_q   <= bad_d;
      armed_q <= armed_d;
    end
  end

  // Press length includes the release cycle, so an N-cycle press measures N.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    len_d   = len_q;
    bad_d   = bad_q;
    armed_d = armed_q;
    ovf_set = 1'b0;
    wg_d    = 1'b0;
    emit    = 1'b0;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_PRESS;
          cnt_d   = '0;
        end
      end
      ST_PRESS: begin
        cnt_d = cnt_inc;
        if (!key) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          if (cnt_inc >= MIN_T) begin
            if (len_q == MAX_LEN) begin
              ovf_set = 1'b1;
              bad_d   = 1'b1;
            end else begin
              if (cnt_inc >= DASH_T)
                buf_d = buf_q | (MAX_SYM'(1) << (MAX_SYM - 1 - int'(len_q)));
              len_d = len_q + 3'd1;
            end
          end
        end
      end
      ST_GAP: begin
        cnt_d = cnt_inc;
        if (rise) begin
          state_d = ST_PRESS;
          cnt_d   = '0;
        end else if (armed_q && len_q == 3'd0 && cnt_q >= WORD_T) begin
          wg_d    = 1'b1;
          armed_d = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == CHAR_T) begin
          if (len_q != 3'd0)
            state_d = ST_EMIT;
          else if (!armed_q)
            state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        // Counter keeps running so the word gap is measured from the last release.
        emit    = 1'b1;
        cnt_d   = cnt_inc;
        buf_d   = '0;
        len_d   = '0;
        bad_d   = 1'b0;
        armed_d = 1'b1;
        state_d = ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_code  <= CHAR_INVALID;
      char_valid <= 1'b0;
      word_gap   <= 1'b0;
      seg_out    <= 7'b0;
      overflow   <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      word_gap <= wg_d;
      if (hs)
        seg_out <= seg_of(char_code);
      if (emit && (!char_valid || char_ready)) begin
        char_code  <= emit_code;
        char_valid <= 1'b1;
      end else if (hs) begin
        char_valid <= 1'b0;
      end
      if (emit && char_valid && !char_ready)
        dropped <= 1'b1;
      if (ovf_set)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Directed bench for morse_rx_decoder with 4-cycle time units: a table of
// characters keyed in and checked, plus glitch, back-pressure and reset sequences.
module tb_morse_rx_decoder;
  import morse_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       button;
  logic [5:0] char_code;
  logic       char_valid;
  logic       char_ready;
  logic       word_gap;
  logic [6:0] seg_out;
  logic       overflow;
  logic       dropped;
  state_t     dbg_state;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int wg_cnt = 0;
  logic [5:0] last_code = 6'd0;

  morse_rx_decoder #(
    .TICKS_PER_UNIT (4),
    .DASH_UNITS     (2),
    .CHAR_GAP_UNITS (3),
    .WORD_GAP_UNITS (7),
    .MAX_SYM        (5),
    .MIN_PRESS_TICKS(2),
    .DEBOUNCE_TICKS (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .button    (button),
    .char_code (char_code),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .word_gap  (word_gap),
    .seg_out   (seg_out),
    .overflow  (overflow),
    .dropped   (dropped),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake and word-gap monitors
  always @(posedge clk) begin
    if (rst_n && char_valid && char_ready) begin
      hs_cnt++;
      last_code = char_code;
    end
    if (rst_n && word_gap)
      wg_cnt++;
  end

  typedef struct {
    string      name;
    string      pat;
    logic [5:0] code;
    logic [6:0] seg;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int n);
    button = 1'b1;
    idle(n);
    button = 1'b0;
  endtask

  initial begin
    int hs0, wg0;
    vecs[0] = '{"U",       "..-",    6'd20, 7'h3E, 1'b0};
    vecs[1] = '{"I",       "..",     6'd8,  7'h30, 1'b0};
    vecs[2] = '{"E",       ".",      6'd4,  7'h79, 1'b0};
    vecs[3] = '{"T",       "-",      6'd19, 7'h78, 1'b0};
    vecs[4] = '{"A",       ".-",     6'd0,  7'h77, 1'b0};
    vecs[5] = '{"D",       "-..",    6'd3,  7'h5E, 1'b0};
    vecs[6] = '{"5",       ".....",  6'd31, 7'h6D, 1'b0};
    vecs[7] = '{"0",       "-----",  6'd26, 7'h3F, 1'b0};
    vecs[8] = '{"unknown", "..--",   6'd63, 7'h40, 1'b0};
    vecs[9] = '{"ovf",     "......", 6'd63, 7'h40, 1'b1};

    rst_n      = 1'b0;
    button     = 1'b0;
    char_ready = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    check("rst_code",  32'(char_code),  32'd63);
    check("rst_valid", 32'(char_valid), 32'd0);
    check("rst_seg",   32'(seg_out),    32'd0);
    check("rst_ovf",   32'(overflow),   32'd0);
    check("rst_drop",  32'(dropped),    32'd0);
    check("rst_wg",    32'(word_gap),   32'd0);
    check("rst_state", 32'(dbg_state),  32'd0);

    for (int i = 0; i < 10; i++) begin
      hs0 = hs_cnt;
      wg0 = wg_cnt;
      for (int j = 0; j < vecs[i].pat.len(); j++) begin
        press((vecs[i].pat[j] == 8'h2D) ? 10 : 4);
        idle(4);
      end
      idle(40);
      check({vecs[i].name, "_code"}, 32'(last_code),       32'(vecs[i].code));
      check({vecs[i].name, "_hs"},   32'(hs_cnt - hs0),    32'd1);
      check({vecs[i].name, "_seg"},  32'(seg_out),         32'(vecs[i].seg));
      check({vecs[i].name, "_wg"},   32'(wg_cnt - wg0),    32'd1);
      check({vecs[i].name, "_ovf"},  32'(overflow),        32'(vecs[i].ovf));
      check({vecs[i].name, "_vld"},  32'(char_valid),      32'd0);
    end

    // Short glitch during the gap after a dot must not add a symbol.
    hs0 = hs_cnt;
    press(4);
    idle(4);
    press(1);
    idle(40);
    check("glitch_code", 32'(last_code),    32'd4);
    check("glitch_hs",   32'(hs_cnt - hs0), 32'd1);
    check("glitch_seg",  32'(seg_out),      32'h79);

`ifdef MORSE_DEBOUNCE_EN
    // Key chatter every 3 cycles is shorter than the debounce window.
    hs0 = hs_cnt;
    wg0 = wg_cnt;
    for (int k = 0; k < 4; k++) begin
      button = (k % 2 == 0);
      idle(3);
    end
    button = 1'b0;
    idle(40);
    check("deb_hs",    32'(hs_cnt - hs0), 32'd0);
    check("deb_wg",    32'(wg_cnt - wg0), 32'd0);
    check("deb_state", 32'(dbg_state),    32'd0);
`endif

    // Back-pressure: E held, T arrives while output full and is lost.
    hs0 = hs_cnt;
    char_ready = 1'b0;
    press(4);
    idle(20);
    check("bp_e_valid", 32'(char_valid), 32'd1);
    check("bp_e_drop",  32'(dropped),    32'd0);
    press(10);
    idle(40);
    check("bp_valid", 32'(char_valid),   32'd1);
    check("bp_code",  32'(char_code),    32'd4);
    check("bp_drop",  32'(dropped),      32'd1);
    check("bp_hs",    32'(hs_cnt - hs0), 32'd0);
    char_ready = 1'b1;
    idle(1);
    check("bp_hs_after", 32'(hs_cnt - hs0), 32'd1);
    check("bp_seg",      32'(seg_out),      32'h79);
    check("bp_vld_after", 32'(char_valid),  32'd0);

    // Reset in the middle of a dash abandons the character.
    hs0 = hs_cnt;
    wg0 = wg_cnt;
    press(6);
    button = 1'b1;
    rst_n  = 1'b0;
    idle(2);
    button = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(40);
    check("mid_rst_hs",    32'(hs_cnt - hs0), 32'd0);
    check("mid_rst_wg",    32'(wg_cnt - wg0), 32'd0);
    check("mid_rst_valid", 32'(char_valid),   32'd0);
    check("mid_rst_code",  32'(char_code),    32'd63);
    check("mid_rst_seg",   32'(seg_out),      32'd0);
    check("mid_rst_ovf",   32'(overflow),     32'd0);
    check("mid_rst_drop",  32'(dropped),      32'd0);
    check("mid_rst_state", 32'(dbg_state),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
